reg_file: RTL and testbench
===========================

Name: reg_file

Overview:
- General-purpose register file sitting directly downstream of the instruction-sequencing control unit.
- Consumes that unit's select, output-enable, load and count strobes.
- Drives two shared 32-bit operand buses (A and B), which feed the ALU and the memory address/data paths.
- Accepts one write per cycle from the result bus.
- Supports post-increment of the register being read, which implements PC++ during fetch and pointer stepping.

Parameters:
- WIDTH, 32, register and bus width in bits.
- NUM_REGS, 16, number of registers; select width is $clog2(NUM_REGS).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- oe_a  in  1  drive register sel_a onto out_a.
- oe_b  in  1  drive register sel_b onto out_b.
- ld  in  1  write in_data into register sel_in at clock edge.
- sel_a  in  4 (reg_e)  A-port register select.
- sel_b  in  4 (reg_e)  B-port register select.
- sel_in  in  4 (reg_e)  write-port register select.
- count_a  in  8  post-increment amount for sel_a, applied only when oe_a=1.
- count_b  in  8  post-increment amount for sel_b, applied only when oe_b=1.
- in_data  in  WIDTH  result bus.
- out_a  out  WIDTH  A bus; 'z when oe_a=0.
- out_b  out  WIDTH  B bus; 'z when oe_b=0.
- pc_out  out  WIDTH  always-driven copy of PC, for debug/trace.

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- Reset: on the rising edge with rst=1, all registers become 0, so pc_out=0. out_a/out_b follow their oe inputs combinationally (high-Z unless enabled). rst has priority over ld and count.
- Reads:
  - Combinational, zero latency: out_a = regs[sel_a] when oe_a, else 'z; same rule for out_b.
  - This is required because fetch asserts oe_b and mem_rd in the same cycle.
- No write bypass: a read in the same cycle as a write to the same register returns the old value; the new value is visible the next cycle.
- Write: at posedge, if ld, regs[sel_in] <= in_data.
- Post-increment:
  - At posedge, if oe_a and count_a != 0, regs[sel_a] <= regs[sel_a] + zero-extend(count_a). Likewise for the B port.
  - The bus carries the pre-increment value (post-increment semantics).
- Arithmetic: modulo 2^WIDTH, silent wrap (e.g. 0xFFFF_FFFF + 1 = 0). No flags are produced.
- Simultaneous events, in priority order:
  1. ld to the same register as an active count: ld wins and the increment is discarded.
  2. Both ports counting the same register: increments sum (regs + count_a + count_b).
  3. Counts and ld on different registers: all take effect in the same edge.
- Count with oe deasserted: ignored.
- Out-of-range selects (NUM_REGS not a power of two): read returns 0, write/count ignored.
- No state machine; all state is the register array. The B-port count path is the fetch-critical path.

Decomposition:
- reg_pkg holds:
  - reg_e: 4-bit enum, R0..R12 = 0..12, SP = 13, LR = 14, PC = 15.
  - REG_W = 4.
- reg_file uses the reg_pkg::PC constant for pc_out.
- One sub-module, bus_driver (WIDTH-parameterised tri-state buffer: en, d, q), instantiated for out_a and out_b.
- The increment/priority logic stays inline in reg_file.

Test Plan:
- Reset: preload R3=0x1234 via ld, pulse rst with ld=1 on the same edge → R3=0, pc_out=0; out_a='z with oe_a=0.
- Fetch increment: PC=0x10; sel_b=PC, oe_b=1, count_b=1 for one cycle → out_b=0x10 during the cycle; pc_out=0x11 after the edge. Repeat with count_b=4 → 0x15.
- Write/read no bypass: ld=1, sel_in=R2, in_data=0xDEADBEEF, oe_a=1, sel_a=R2 (old 0x5) → out_a=0x5 in that cycle, 0xDEADBEEF the next.
- Conflict: PC=0x20; ld to PC with in_data=0x100, and oe_b/count_b=1 on PC → PC=0x100 (ld wins).
- Dual count and wrap:
  - R1=0xFFFF_FFFE; sel_a=sel_b=R1, count_a=1, count_b=2 → R1=0x0000_0001.
  - count_a=5 with oe_a=0 → R1 unchanged.
- Two ports, distinct registers: sel_a=R4 (0xA), sel_b=R5 (0xB), oe both, ld R6=0xC → out_a=0xA, out_b=0xB the same cycle; R6=0xC next.

Source files
------------

// File: rtl/reg_pkg.sv
// reg_pkg: register names and select width shared by the register file slice
package reg_pkg;
  localparam int REG_W = 4;
  typedef enum logic [REG_W-1:0] {
    R0, R1, R2, R3, R4, R5, R6, R7, R8, R9, R10, R11, R12,
    SP = 4'd13, LR = 4'd14, PC = 4'd15
  } reg_e;
endpackage

// File: rtl/reg_file_if.sv
// reg_file_if: control-unit strobes, result bus and operand buses of the register file
interface reg_file_if import reg_pkg::*; #(parameter int WIDTH = 32);
  logic             oe_a, oe_b, ld;
  reg_e             sel_a, sel_b, sel_in;
  logic [7:0]       count_a, count_b;
  logic [WIDTH-1:0] in_data, out_a, out_b, pc_out;
  modport master (output oe_a, oe_b, ld, sel_a, sel_b, sel_in, count_a, count_b, in_data,
                  input out_a, out_b, pc_out);
  modport slave  (input oe_a, oe_b, ld, sel_a, sel_b, sel_in, count_a, count_b, in_data,
                  output out_a, out_b, pc_out);
endinterface

// File: rtl/bus_driver.sv
// bus_driver: tri-state buffer onto a shared operand bus
module bus_driver #(parameter int WIDTH = 32) (
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  assign q = en ? d : 'z;
endmodule

// File: rtl/reg_file.sv
// reg_file: dual-read register file with one write port and post-increment on each read port
module reg_file import reg_pkg::*; #(
  parameter int WIDTH    = 32,
  parameter int NUM_REGS = 16
) (
  input logic       clk,
  input logic       rst,
  reg_file_if.slave bus
);
  logic [WIDTH-1:0] regs [NUM_REGS];
  logic [WIDTH-1:0] rd_a, rd_b;
  logic             ok_a, ok_b, ok_in, inc_a, inc_b, wr;
  always_comb begin
    ok_a  = int'(bus.sel_a) < NUM_REGS;
    ok_b  = int'(bus.sel_b) < NUM_REGS;
    ok_in = int'(bus.sel_in) < NUM_REGS;
    rd_a  = ok_a ? regs[bus.sel_a] : '0;
    rd_b  = ok_b ? regs[bus.sel_b] : '0;
    inc_a = bus.oe_a && ok_a && bus.count_a != 8'd0;
    inc_b = bus.oe_b && ok_b && bus.count_b != 8'd0;
    wr    = bus.ld && ok_in;
  end
  // ld overrides any increment on the same register; both ports' increments add together
  always_ff @(posedge clk)
    for (int i = 0; i < NUM_REGS; i++)
      if (rst) regs[i] <= '0;
      else if (wr && int'(bus.sel_in) == i) regs[i] <= bus.in_data;
      else regs[i] <= regs[i]
                    + (inc_a && int'(bus.sel_a) == i ? WIDTH'(bus.count_a) : '0)
                    + (inc_b && int'(bus.sel_b) == i ? WIDTH'(bus.count_b) : '0);
  assign bus.pc_out = regs[PC];
  bus_driver #(.WIDTH(WIDTH)) u_drv_a (.en(bus.oe_a), .d(rd_a), .q(bus.out_a));
  bus_driver #(.WIDTH(WIDTH)) u_drv_b (.en(bus.oe_b), .d(rd_b), .q(bus.out_b));
endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: randomized and directed scoreboard bench against an array model of the register file
module tb_reg_file;
  import reg_pkg::*;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  reg_file_if #(.WIDTH(32)) bus ();
  reg_file #(.WIDTH(32), .NUM_REGS(16)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  typedef struct { logic oa; logic [31:0] ea; logic ob; logic [31:0] eb; logic [31:0] ep; } exp_t;
  exp_t q[$];
  logic [31:0] m [16];
  int vectors = 0, miscompares = 0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask
  task automatic check_off(input string name, input logic [31:0] act);
    vectors++;
    if (!(act === 32'hz || act === 32'h0)) begin
      miscompares++;
      $display("FAIL %s: got %h, expected high-Z", name, act);
    end
  endtask
  // one clock of stimulus: expectation from current model state, then apply edge rules to the model
  task automatic cyc(input logic r, input logic oa, input reg_e sa, input logic [7:0] ca,
                     input logic ob, input reg_e sb, input logic [7:0] cb,
                     input logic l, input reg_e si, input logic [31:0] d);
    exp_t e;
    logic [31:0] n [16];
    @(posedge clk); #1;
    rst = r; bus.oe_a = oa; bus.sel_a = sa; bus.count_a = ca;
    bus.oe_b = ob; bus.sel_b = sb; bus.count_b = cb;
    bus.ld = l; bus.sel_in = si; bus.in_data = d;
    e.oa = oa; e.ea = m[sa]; e.ob = ob; e.eb = m[sb]; e.ep = m[15];
    q.push_back(e);
    n = m;
    if (oa) n[sa] = n[sa] + 32'(ca);
    if (ob) n[sb] = n[sb] + 32'(cb);
    if (l) n[si] = d;
    if (r) foreach (n[i]) n[i] = 0;
    m = n;
  endtask
  task automatic idle();
    cyc(0, 0, R0, 0, 0, R0, 0, 0, R0, 0);
  endtask
  task automatic wr(input reg_e s, input logic [31:0] d);
    cyc(0, 0, R0, 0, 0, R0, 0, 1, s, d);
  endtask
  task automatic rd_a(input reg_e s);
    cyc(0, 1, s, 0, 0, R0, 0, 0, R0, 0);
  endtask
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        check("pc_out", bus.pc_out, e.ep);
        if (e.oa) check("out_a", bus.out_a, e.ea); else check_off("out_a_z", bus.out_a);
        if (e.ob) check("out_b", bus.out_b, e.eb); else check_off("out_b_z", bus.out_b);
      end
    end
  end
  initial begin
    foreach (m[i]) m[i] = 'x;
    bus.oe_a = 0; bus.oe_b = 0; bus.ld = 0; bus.sel_a = R0; bus.sel_b = R0; bus.sel_in = R0;
    bus.count_a = 0; bus.count_b = 0; bus.in_data = 0;
    @(posedge clk); #1;
    foreach (m[i]) m[i] = 0;
    rst = 0;
    wr(R3, 32'h1234);
    rd_a(R3);
    cyc(1, 0, R3, 0, 0, R0, 0, 1, R3, 32'h5555);
    rd_a(R3);
    wr(PC, 32'h10);
    cyc(0, 0, R0, 0, 1, PC, 1, 0, R0, 0);
    cyc(0, 0, R0, 0, 1, PC, 4, 0, R0, 0);
    idle();
    wr(R2, 32'h5);
    cyc(0, 1, R2, 0, 0, R0, 0, 1, R2, 32'hDEADBEEF);
    rd_a(R2);
    wr(PC, 32'h20);
    cyc(0, 0, R0, 0, 1, PC, 1, 1, PC, 32'h100);
    idle();
    wr(R1, 32'hFFFF_FFFE);
    cyc(0, 1, R1, 1, 1, R1, 2, 0, R0, 0);
    rd_a(R1);
    cyc(0, 0, R1, 5, 0, R0, 0, 0, R0, 0);
    rd_a(R1);
    wr(R4, 32'hA);
    wr(R5, 32'hB);
    cyc(0, 1, R4, 0, 1, R5, 0, 1, R6, 32'hC);
    rd_a(R6);
    for (int k = 0; k < 400; k++) begin
      logic [7:0] ca, cb;
      ca = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
      cb = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
      cyc($urandom_range(0, 63) == 0,
          1'($urandom), reg_e'($urandom_range(0, 15)), ca,
          1'($urandom), reg_e'($urandom_range(0, 15)), cb,
          1'($urandom), reg_e'($urandom_range(0, 15)),
          ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF - 32'($urandom_range(0, 3)) : $urandom);
    end
    idle();
    for (int k = 0; k < 20 && q.size() > 0; k++) @(negedge clk);
    #1;
    if (q.size() > 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
